// File: rtl/edgcol_engine.sv
// Xedgcol responder: walks a Bresenham line from A to B over a 2^CW x 2^CW
// occupancy grid and reports the first occupied cell via HBDone/result.
module edgcol_engine #(
  parameter int COORD_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  edgcolWrEna,
  input  logic [1:0]            wrSel,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  HBStart,
  output logic                  HBDone,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int CW   = COORD_WIDTH;
  localparam int GRID = 2 ** CW;
  localparam int EW   = CW + 2;
  localparam logic [CW-1:0] ONE = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [GRID-1:0][GRID-1:0]  grid_q;
  logic [CW-1:0]              ax_q, ay_q, bx_q, by_q;
  logic [CW-1:0]              cx_q, cy_q, cx_d, cy_d;
  logic signed [EW-1:0]       dx_q, dy_q, err_q, dx_d, dy_d, err_d;
  logic                       sxn_q, syn_q, sxn_d, syn_d;
  logic                       done_q, done_d;
  logic [DATA_WIDTH-1:0]      res_q, res_d;
  logic [CW-1:0]              adx, ady;
  logic signed [EW:0]         e2, dxe, dye;
  logic                       wr_ok;
  logic                       unused_wr;

  assign unused_wr = ^wrData[DATA_WIDTH-1:GRID+CW];

  assign wr_ok = edgcolWrEna && (state_q == S_IDLE || state_q == S_DONE);
  assign adx   = (bx_q >= ax_q) ? bx_q - ax_q : ax_q - bx_q;
  assign ady   = (by_q >= ay_q) ? by_q - ay_q : ay_q - by_q;
  assign e2    = {err_q, 1'b0};
  assign dxe   = {dx_q[EW-1], dx_q};
  assign dye   = {dy_q[EW-1], dy_q};

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    done_d  = done_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (HBStart) begin
          state_d = S_INIT;
          done_d  = 1'b0;
          res_d   = '0;
        end
      end
      S_INIT: begin
        cx_d    = ax_q;
        cy_d    = ay_q;
        dx_d    = $signed({2'b00, adx});
        dy_d    = -$signed({2'b00, ady});
        err_d   = $signed({2'b00, adx}) - $signed({2'b00, ady});
        sxn_d   = bx_q < ax_q;
        syn_d   = by_q < ay_q;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (grid_q[cy_q][cx_q]) begin
          state_d             = S_DONE;
          done_d              = 1'b1;
          res_d               = '0;
          res_d[0]            = 1'b1;
          res_d[CW:1]         = cx_q;
          res_d[2*CW:CW+1]    = cy_q;
        end else if (cx_q == bx_q && cy_q == by_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          res_d   = '0;
        end else begin
          // both tests use the pre-step error so a diagonal move is one cycle
          if (e2 >= dye) begin
            err_d = err_d + dy_q;
            cx_d  = sxn_q ? cx_q - ONE : cx_q + ONE;
          end
          if (e2 <= dxe) begin
            err_d = err_d + dx_q;
            cy_d  = syn_q ? cy_q - ONE : cy_q + ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grid_q  <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      done_q  <= done_d;
      res_q   <= res_d;
      if (wr_ok) begin
        case (wrSel)
          2'b00:   {ay_q, ax_q} <= wrData[2*CW-1:0];
          2'b01:   {by_q, bx_q} <= wrData[2*CW-1:0];
          2'b10:   grid_q[wrData[GRID+CW-1:GRID]] <= wrData[GRID-1:0];
          default: grid_q <= '0;
        endcase
      end
    end
  end

  assign HBDone = done_q;
  assign busy   = (state_q == S_INIT) || (state_q == S_STEP);
  assign result = res_q;
endmodule

// File: tb/tb_edgcol_engine.sv
// Randomized self-checking bench for edgcol_engine against a plain Bresenham model.
module tb_edgcol_engine;
  logic        clk = 1'b0;
  logic        rst, ena, start;
  logic [1:0]  sel;
  logic [31:0] data;
  logic        done, busy;
  logic [31:0] res;

  int nchk = 0;
  int nfail = 0;
  bit gm[16][16];
  int px[$];
  int py[$];

  always #5 clk = ~clk;

  edgcol_engine #(.COORD_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .edgcolWrEna(ena), .wrSel(sel), .wrData(data),
    .HBStart(start), .HBDone(done), .busy(busy), .result(res)
  );

  function automatic void model(input int ax, input int ay, input int bx, input int by,
                                output int n, output logic [31:0] r);
    int x, y, dx, dy, sx, sy, err, e2;
    x = ax; y = ay;
    dx = (bx > ax) ? bx - ax : ax - bx;
    dy = -((by > ay) ? by - ay : ay - by);
    sx = (bx >= ax) ? 1 : -1;
    sy = (by >= ay) ? 1 : -1;
    err = dx + dy;
    n = 0; r = 0;
    px.delete(); py.delete();
    while (n < 64) begin
      n++;
      px.push_back(x); py.push_back(y);
      if (gm[y][x]) begin
        r = 32'((y << 5) | (x << 1) | 1);
        return;
      end
      if (x == bx && y == by) return;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    @(negedge clk); ena = 1'b1; sel = s; data = d;
    @(negedge clk); ena = 1'b0;
  endtask

  task automatic set_a(input int x, input int y); wr(2'b00, 32'((y << 4) | x)); endtask
  task automatic set_b(input int x, input int y); wr(2'b01, 32'((y << 4) | x)); endtask

  task automatic set_row(input int y, input logic [15:0] bm);
    for (int i = 0; i < 16; i++) gm[y][i] = bm[i];
    wr(2'b10, 32'((y << 16) | bm));
  endtask

  task automatic clr();
    foreach (gm[i, j]) gm[i][j] = 1'b0;
    wr(2'b11, 32'd0);
  endtask

  // lat = cycles from the start edge to HBDone high, -1 on timeout
  task automatic walk(output int lat, output logic [31:0] r, output logic d0);
    int c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    d0 = done;
    c = 0; lat = -1;
    while (c < 60) begin
      @(negedge clk); c++;
      if (done) begin lat = c; break; end
    end
    r = res;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] r; logic d0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL reset_done: got %b want 0", done); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
    nchk++; if (res !== 32'd0) begin nfail++; $display("FAIL reset_result: got %h want 0", res); end
    walk(lat, r, d0);
    nchk++; if (lat != 2) begin nfail++; $display("FAIL reset_walk_lat: got %0d want 2", lat); end
    nchk++; if (r !== 32'd0) begin nfail++; $display("FAIL reset_walk_result: got %h want 0", r); end
  endtask

  task automatic test_single_point();
    int lat; logic [31:0] r; logic d0;
    clr(); set_a(2, 2); set_b(2, 2);
    walk(lat, r, d0);
    nchk++; if (d0 !== 1'b0) begin nfail++; $display("FAIL single_done_after_start: got %b want 0", d0); end
    nchk++; if (lat != 2) begin nfail++; $display("FAIL single_lat: got %0d want 2", lat); end
    nchk++; if (r !== 32'd0) begin nfail++; $display("FAIL single_result: got %h want 0", r); end
  endtask

  task automatic test_hit_row();
    int lat; logic [31:0] r; logic d0;
    clr(); set_a(0, 0); set_b(5, 0); set_row(0, 16'h0008);
    walk(lat, r, d0);
    nchk++; if (lat != 5) begin nfail++; $display("FAIL hit_row_lat: got %0d want 5", lat); end
    nchk++; if (r !== 32'h7) begin nfail++; $display("FAIL hit_row_result: got %h want 7", r); end
  endtask

  task automatic test_diagonal();
    int lat; logic [31:0] r; logic d0;
    clr(); set_a(0, 0); set_b(15, 15);
    walk(lat, r, d0);
    nchk++; if (lat != 17) begin nfail++; $display("FAIL diag_lat: got %0d want 17", lat); end
    nchk++; if (r !== 32'd0) begin nfail++; $display("FAIL diag_result: got %h want 0", r); end
  endtask

  task automatic test_reverse();
    int lat, n; logic [31:0] r, er; logic d0;
    int qx[$]; int qy[$];
    clr(); set_a(9, 2); set_b(1, 6); set_row(4, 16'h0020);
    walk(lat, r, d0);
    nchk++; if (r !== 32'h8B) begin nfail++; $display("FAIL reverse_result: got %h want 8b", r); end
    nchk++; if (lat != 6) begin nfail++; $display("FAIL reverse_lat: got %0d want 6", lat); end
    // probe every cell of the reference path with a lone obstacle
    clr();
    model(9, 2, 1, 6, n, er);
    qx = px; qy = py;
    for (int i = 0; i < qx.size(); i++) begin
      clr(); set_row(qy[i], 16'(1 << qx[i]));
      model(9, 2, 1, 6, n, er);
      walk(lat, r, d0);
      nchk++; if (r !== er || lat != i + 2)
        begin nfail++; $display("FAIL reverse_path[%0d]: got %h/%0d want %h/%0d", i, r, lat, er, i + 2); end
    end
  endtask

  task automatic test_busy_ignore_and_reset();
    int lat, c; logic [31:0] r; logic d0; bit stray;
    clr(); set_a(0, 0); set_b(15, 15);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0; lat = -1;
    while (c < 60) begin
      @(negedge clk); c++;
      if (c == 4) begin start = 1'b1; ena = 1'b1; sel = 2'b01; data = 32'h11; end
      if (c == 5) begin start = 1'b0; ena = 1'b0; end
      if (done) begin lat = c; break; end
    end
    nchk++; if (lat != 17) begin nfail++; $display("FAIL busy_ignore_lat: got %0d want 17", lat); end
    nchk++; if (res !== 32'd0) begin nfail++; $display("FAIL busy_ignore_result: got %h want 0", res); end
    set_row(7, 16'h0080);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    nchk++; if (done !== 1'b0 || busy !== 1'b0 || res !== 32'd0)
      begin nfail++; $display("FAIL midwalk_reset: got done=%b busy=%b res=%h want 0/0/0", done, busy, res); end
    stray = 1'b0;
    repeat (20) begin @(negedge clk); if (done || busy) stray = 1'b1; end
    nchk++; if (stray) begin nfail++; $display("FAIL abandoned_walk_done: got activity want none"); end
    foreach (gm[i, j]) gm[i][j] = 1'b0;
    set_a(0, 0); set_b(15, 15);
    walk(lat, r, d0);
    nchk++; if (lat != 17 || r !== 32'd0)
      begin nfail++; $display("FAIL grid_cleared_walk: got %0d/%h want 17/0", lat, r); end
    walk(lat, r, d0);
    nchk++; if (d0 !== 1'b0) begin nfail++; $display("FAIL done_drop_on_restart: got %b want 0", d0); end
  endtask

  task automatic test_start_with_write();
    int lat, c, n; logic [31:0] er;
    clr(); set_a(0, 0); set_b(15, 15); set_row(2, 16'h0004);
    @(negedge clk); start = 1'b1; ena = 1'b1; sel = 2'b01; data = 32'h33;
    @(negedge clk); start = 1'b0; ena = 1'b0;
    c = 0; lat = -1;
    while (c < 60) begin
      @(negedge clk); c++;
      if (done) begin lat = c; break; end
    end
    model(0, 0, 3, 3, n, er);
    nchk++; if (lat != n + 1 || res !== er)
      begin nfail++; $display("FAIL start_with_write: got %0d/%h want %0d/%h", lat, res, n + 1, er); end
  endtask

  task automatic test_random();
    int lat, n, ax, ay, bx, by; logic [31:0] r, er; logic d0;
    for (int it = 0; it < 40; it++) begin
      clr();
      for (int j = 0; j < 3; j++)
        set_row($urandom_range(0, 15), 16'($urandom & $urandom & $urandom));
      ax = $urandom_range(0, 15); ay = $urandom_range(0, 15);
      bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
      set_a(ax, ay); set_b(bx, by);
      model(ax, ay, bx, by, n, er);
      walk(lat, r, d0);
      nchk++; if (lat != n + 1 || r !== er || d0 !== 1'b0)
        begin nfail++; $display("FAIL random[%0d] (%0d,%0d)->(%0d,%0d): got %0d/%h want %0d/%h",
                                 it, ax, ay, bx, by, lat, r, n + 1, er); end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; sel = 2'b00; data = 32'd0; start = 1'b0;
    test_reset();
    test_single_point();
    test_hit_row();
    test_diagonal();
    test_reverse();
    test_busy_ignore_and_reset();
    test_start_with_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
